mac_pipe: RTL and testbench

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_pipe_pkg.sv | 22 ++
 rtl/pipe_delay.sv | 52 +++++
 rtl/mac_pipe.sv | 147 ++++++++++++++
 tb/tb_mac_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pipe_pkg.sv
// Shared encodings and legal parameter ranges for the mac_pipe slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pipe_pkg;

  localparam int WIDTH_MIN   = 8;
  localparam int WIDTH_MAX   = 64;
  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 8;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_MAC = 1'b1
  } mode_e;

  function automatic bit params_legal(input int width, input int latency, input int signed_ops);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX) &&
           ((signed_ops == 0) || (signed_ops == 1));
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Valid-qualified shift register: carries a data word and its valid bit DEPTH stages.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; a new entry may enter every cycle, idle stages hold their data.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  if (DEPTH == 0) begin : g_pass
    assign out_vld = in_vld;
    assign out_dat = in_dat;
  end else begin : g_regs
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Valid bits shift every cycle; a data slot only loads when a valid entry moves into it.
    always_comb begin
      vld_d[0] = in_vld;
      dat_d[0] = in_vld ? in_dat : dat_q[0];
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
    end

    // Stage registers; reset drops every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply / multiply-accumulate with wrap-around result and overflow flag.
// Latency: LATENCY cycles from issue (t=1) to out_valid; one issue per cycle.
// Backpressure: none; the pipe never stalls, results leave in issue order.
module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int SIGNED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             ovf
);

  if (!params_legal(WIDTH, LATENCY, SIGNED)) begin : g_bad_param
    $error("mac_pipe: WIDTH/LATENCY/SIGNED outside legal range");
  end

  localparam int PW       = 2 * WIDTH;
  localparam bit SIGNED_B = (SIGNED != 0);

  // Stage 1: capture operands and tags on issue.
  logic             s1_vld;
  logic [PW+1:0]    s1_dat;
  logic             s1_mode;
  logic             s1_clr;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  pipe_delay #(.WIDTH(PW + 2), .DEPTH(1)) u_opnd (
    .clk     (clk),
    .rst_n   (rst),
    .in_vld  (t),
    .in_dat  ({mode, acc_clr, a, b}),
    .out_vld (s1_vld),
    .out_dat (s1_dat)
  );

  assign {s1_mode, s1_clr, s1_a, s1_b} = s1_dat;

  // Full-width product; sign- or zero-extension makes the low 2*WIDTH bits exact either way.
  logic [PW-1:0] ext_a;
  logic [PW-1:0] ext_b;
  logic [PW-1:0] prod_full;

  // Extend operands to product width and multiply.
  always_comb begin
    ext_a     = {{WIDTH{s1_a[WIDTH-1] & SIGNED_B}}, s1_a};
    ext_b     = {{WIDTH{s1_b[WIDTH-1] & SIGNED_B}}, s1_b};
    prod_full = ext_a * ext_b;
  end

  // Middle stages: product travels with its mode/acc_clr tags up to the final stage.
  logic          fin_vld;
  logic [PW+1:0] fin_dat;
  logic          fin_mode;
  logic          fin_clr;
  logic [PW-1:0] fin_prod;

  pipe_delay #(.WIDTH(PW + 2), .DEPTH(LATENCY - 2)) u_prod (
    .clk     (clk),
    .rst_n   (rst),
    .in_vld  (s1_vld),
    .in_dat  ({s1_mode, s1_clr, prod_full}),
    .out_vld (fin_vld),
    .out_dat (fin_dat)
  );

  assign {fin_mode, fin_clr, fin_prod} = fin_dat;

  // Final stage state.
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;
  logic             ovf_d, ovf_q;

  logic [WIDTH-1:0] prod_lo;
  logic             prod_ovf;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;

  // Truncate product, detect product/add overflow, and apply the tag-selected operation.
  always_comb begin
    prod_lo  = fin_prod[WIDTH-1:0];
    if (SIGNED_B) begin
      prod_ovf = (fin_prod[PW-1:WIDTH-1] != {(WIDTH+1){fin_prod[WIDTH-1]}});
    end else begin
      prod_ovf = |fin_prod[PW-1:WIDTH];
    end
    acc_base = fin_clr ? '0 : acc_q;
    sum_ext  = {1'b0, acc_base} + {1'b0, prod_lo};
    sum      = sum_ext[WIDTH-1:0];
    if (SIGNED_B) begin
      add_ovf = (acc_base[WIDTH-1] == prod_lo[WIDTH-1]) && (sum[WIDTH-1] != acc_base[WIDTH-1]);
    end else begin
      add_ovf = sum_ext[WIDTH];
    end

    out_d       = out_q;
    acc_d       = acc_q;
    ovf_d       = 1'b0;
    out_valid_d = fin_vld;
    if (fin_vld) begin
      if (mode_e'(fin_mode) == MODE_MAC) begin
        acc_d = sum;
        out_d = sum;
        ovf_d = prod_ovf | add_ovf;
      end else begin
        out_d = prod_lo;
        ovf_d = prod_ovf;
        if (fin_clr) begin
          acc_d = '0;
        end
      end
    end
  end

  // Output and accumulator registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: a signed and an unsigned instance share one stimulus stream.
// Expected results are queued at issue and popped when out_valid appears.
// Results must arrive exactly LAT cycles after issue, in order.
module tb_mac_pipe;

  localparam int LAT = 3;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mode = 1'b0;
  logic        acc_clr = 1'b0;

  logic [31:0] out_s, out_u;
  logic        vld_s, vld_u, ovf_s, ovf_u;

  mac_pipe #(.WIDTH(32), .LATENCY(LAT), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .t(t), .a(a), .b(b), .mode(mode), .acc_clr(acc_clr),
    .out(out_s), .out_valid(vld_s), .ovf(ovf_s)
  );

  mac_pipe #(.WIDTH(32), .LATENCY(LAT), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .t(t), .a(a), .b(b), .mode(mode), .acc_clr(acc_clr),
    .out(out_u), .out_valid(vld_u), .ovf(ovf_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] s_out;
    logic        s_ovf;
    logic [31:0] u_out;
    logic        u_ovf;
    int          due;
  } exp_t;

  exp_t expq[$];
  logic [31:0] acc_s = '0;
  logic [31:0] acc_u = '0;
  logic [31:0] last_s = '0;
  logic [31:0] last_u = '0;

  // Reference model: 64-bit arithmetic for both signednesses, range-checked.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic m, input logic c,
                       output logic [31:0] so, output logic sov,
                       output logic [31:0] uo, output logic uov);
    int sx, sy, sbase, slo;
    longint sp, ss;
    longint unsigned up, us;
    logic [31:0] ubase;
    sx = x;
    sy = y;
    sp = longint'(sx) * longint'(sy);
    slo = sp[31:0];
    sov = (sp > S_MAX) || (sp < S_MIN);
    up = {32'd0, x} * {32'd0, y};
    uov = (up[63:32] != 32'd0);
    if (m) begin
      sbase = c ? 0 : acc_s;
      ss = longint'(sbase) + longint'(slo);
      so = ss[31:0];
      sov = sov || (ss > S_MAX) || (ss < S_MIN);
      acc_s = so;
      ubase = c ? 32'd0 : acc_u;
      us = {32'd0, ubase} + {32'd0, up[31:0]};
      uo = us[31:0];
      uov = uov || us[32];
      acc_u = uo;
    end else begin
      so = sp[31:0];
      uo = up[31:0];
      if (c) begin
        acc_s = '0;
        acc_u = '0;
      end
    end
  endtask

  // Drive one issue in the current cycle and queue its expectation.
  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic m, input logic c,
                       input bit slit, input logic [31:0] eso, input logic esov,
                       input bit ulit, input logic [31:0] euo, input logic euov);
    exp_t e;
    model(x, y, m, c, e.s_out, e.s_ovf, e.u_out, e.u_ovf);
    if (slit) begin
      e.s_out = eso;
      e.s_ovf = esov;
    end
    if (ulit) begin
      e.u_out = euo;
      e.u_ovf = euov;
    end
    e.due = cyc + LAT;
    expq.push_back(e);
    t = 1'b1; a = x; b = y; mode = m; acc_clr = c;
  endtask

  task automatic iss(input logic [31:0] x, input logic [31:0] y, input logic m, input logic c);
    @(posedge clk); #1;
    drive(x, y, m, c, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic iss_s(input logic [31:0] x, input logic [31:0] y, input logic m, input logic c,
                       input logic [31:0] eo, input logic eov);
    @(posedge clk); #1;
    drive(x, y, m, c, 1'b1, eo, eov, 1'b0, '0, 1'b0);
  endtask

  task automatic iss_u(input logic [31:0] x, input logic [31:0] y, input logic m, input logic c,
                       input logic [31:0] eo, input logic eov);
    @(posedge clk); #1;
    drive(x, y, m, c, 1'b0, '0, 1'b0, 1'b1, eo, eov);
  endtask

  // Idle cycles with junk on the operand pins, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      t = 1'b0; a = $urandom; b = $urandom; mode = 1'($urandom); acc_clr = 1'($urandom);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (expq.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending results=%0d, required 0", expq.size());
      expq.delete();
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_s = '0;
      last_u = '0;
    end else begin
      if (expq.size() > 0 && expq[0].due < cyc) begin
        e = expq.pop_front();
        total++;
        bad++;
        $display("FAIL missing: no out_valid at cyc=%0d, required result %h", e.due, e.s_out);
      end
      if (vld_s || vld_u) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected: out_valid s=%b u=%b at cyc=%0d with nothing in flight",
                   vld_s, vld_u, cyc);
        end else begin
          e = expq.pop_front();
          if (vld_s !== 1'b1 || vld_u !== 1'b1 || e.due != cyc ||
              out_s !== e.s_out || ovf_s !== e.s_ovf || out_u !== e.u_out || ovf_u !== e.u_ovf) begin
            bad++;
            $display("FAIL result: cyc=%0d vld=%b/%b sig out=%h ovf=%b uns out=%h ovf=%b; required cyc=%0d sig out=%h ovf=%b uns out=%h ovf=%b",
                     cyc, vld_s, vld_u, out_s, ovf_s, out_u, ovf_u, e.due, e.s_out, e.s_ovf, e.u_out, e.u_ovf);
          end
        end
        last_s = out_s;
        last_u = out_u;
      end else begin
        total++;
        if (out_s !== last_s || out_u !== last_u || ovf_s !== 1'b0 || ovf_u !== 1'b0) begin
          bad++;
          $display("FAIL hold: cyc=%0d out=%h/%h ovf=%b/%b, required out=%h/%h ovf=0/0",
                   cyc, out_s, out_u, ovf_s, ovf_u, last_s, last_u);
        end
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total++;
    if (out_s !== 32'd0 || out_u !== 32'd0) begin
      bad++;
      $display("FAIL reset_out: out=%h/%h, required 0", out_s, out_u);
    end
    total++;
    if (vld_s !== 1'b0 || vld_u !== 1'b0) begin
      bad++;
      $display("FAIL reset_vld: out_valid=%b/%b, required 0", vld_s, vld_u);
    end
    total++;
    if (ovf_s !== 1'b0 || ovf_u !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: ovf=%b/%b, required 0", ovf_s, ovf_u);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    iss_s(32'd7, 32'd6, 1'b0, 1'b0, 32'd42, 1'b0);
    idle(6);
  endtask

  task automatic test_back_to_back();
    iss_s(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 32'hFFFFFFF1, 1'b0);
    iss_s(32'd4, 32'd4, 1'b0, 1'b0, 32'd16, 1'b0);
    idle(6);
  endtask

  task automatic test_mac();
    iss_s(32'd2, 32'd3, 1'b1, 1'b1, 32'd6, 1'b0);
    iss_s(32'd4, 32'd5, 1'b1, 1'b0, 32'd26, 1'b0);
    iss_s(32'd1, 32'd1, 1'b1, 1'b0, 32'd27, 1'b0);
    idle(6);
  endtask

  task automatic test_mul_acc_interplay();
    // multiply-only leaves acc (27) intact
    iss_s(32'd10, 32'd10, 1'b0, 1'b0, 32'd100, 1'b0);
    iss_s(32'd1, 32'd1, 1'b1, 1'b0, 32'd28, 1'b0);
    // multiply-only with acc_clr zeroes acc but still outputs the product
    iss_s(32'd3, 32'd3, 1'b0, 1'b1, 32'd9, 1'b0);
    iss_s(32'd1, 32'd2, 1'b1, 1'b0, 32'd2, 1'b0);
    idle(6);
  endtask

  task automatic test_ovf();
    iss_s(32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'd0, 1'b1);
    iss_s(32'd2, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0);
    iss_s(32'h7FFFFFFF, 32'd1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0);
    iss_s(32'd1, 32'd1, 1'b1, 1'b0, 32'h80000000, 1'b1);
    idle(6);
  endtask

  task automatic test_unsigned();
    iss_u(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1);
    iss_u(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 32'hFFFFFFF1, 1'b1);
    iss_u(32'd4, 32'd4, 1'b0, 1'b0, 32'd16, 1'b0);
    iss_u(32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    iss_u(32'd1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1);
    idle(6);
  endtask

  task automatic test_flush();
    iss(32'd2, 32'd3, 1'b1, 1'b1);
    iss(32'd4, 32'd5, 1'b1, 1'b0);
    @(posedge clk); #1;
    t = 1'b0;
    rst = 1'b0;
    expq.delete();
    acc_s = '0;
    acc_u = '0;
    #1;
    total++;
    if (out_s !== 32'd0 || vld_s !== 1'b0 || ovf_s !== 1'b0 ||
        out_u !== 32'd0 || vld_u !== 1'b0 || ovf_u !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: out=%h/%h vld=%b/%b ovf=%b/%b, required all 0",
               out_s, out_u, vld_s, vld_u, ovf_s, ovf_u);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(32'd5, 32'd5, 1'b1, 1'b0, 1'b1, 32'd25, 1'b0, 1'b1, 32'd25, 1'b0);
    idle(8);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 60; i++) begin
      x = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
      y = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
      if ($urandom_range(0, 3) != 0) begin
        iss(x, y, 1'($urandom), ($urandom_range(0, 3) == 0));
      end else begin
        idle(1);
      end
    end
    idle(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_mac();
    test_mul_acc_interplay();
    test_ovf();
    test_unsigned();
    test_flush();
    test_random();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
